// File: rtl/sha1_pkg.sv
// Shared types, constants and rotate helpers for the SHA-1 compression engine.
package sha1_pkg;

  localparam int WORD_W = 32;
  localparam int ROUNDS = 80;

  typedef logic [WORD_W-1:0] word_t;
  // Five words; index 4 sits in the top bits (a / H0), index 0 at the bottom (e / H4).
  typedef word_t [4:0] state160_t;

  localparam word_t K0 = 32'h5A827999;
  localparam word_t K1 = 32'h6ED9EBA1;
  localparam word_t K2 = 32'h8F1BBCDC;
  localparam word_t K3 = 32'hCA62C1D6;

  localparam state160_t H_INIT = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                  32'h10325476, 32'hC3D2E1F0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } cmp_state_t;

  function automatic word_t rotl5(input word_t x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic word_t rotl30(input word_t x);
    return {x[1:0], x[31:2]};
  endfunction

endpackage

// File: rtl/sha1_compress_if.sv
// Bus between the compression engine, the schedule source and the chaining logic.
// Handshake: a request is accepted on the first rising edge where cmp_en and
// ext_done are both high while the engine is idle or in its done cycle; busy
// stays high from that edge until the done cycle, cmp_done is a one-cycle
// strobe marking digest valid, and msg_word must answer msg_idx in the same cycle.
interface sha1_compress_if;
  import sha1_pkg::*;

  logic       cmp_en;
  logic       ext_done;
  state160_t  hash_in;
  logic [6:0] msg_idx;
  word_t      msg_word;
  logic       busy;
  logic       cmp_done;
  state160_t  digest;

  modport master (
    output cmp_en, ext_done, hash_in, msg_word,
    input  msg_idx, busy, cmp_done, digest
  );

  modport slave (
    input  cmp_en, ext_done, hash_in, msg_word,
    output msg_idx, busy, cmp_done, digest
  );

endinterface

// File: rtl/sha1_round.sv
// One combinational SHA-1 round: selects f/K by round index and shifts a..e.
module sha1_round
  import sha1_pkg::*;
(
  input  state160_t  i_abcde,
  input  word_t      i_w,
  input  logic [6:0] i_t,
  output state160_t  o_abcde
);

  word_t w_a, w_b, w_c, w_d, w_e;
  word_t w_f, w_k, w_temp;

  assign w_a = i_abcde[4];
  assign w_b = i_abcde[3];
  assign w_c = i_abcde[2];
  assign w_d = i_abcde[1];
  assign w_e = i_abcde[0];

  // Round function and constant chosen by the 20-round group of t.
  always_comb begin
    w_f = '0;
    w_k = '0;
    if (i_t < 7'd20) begin
      w_f = (w_b & w_c) | (~w_b & w_d);
      w_k = K0;
    end else if (i_t < 7'd40) begin
      w_f = w_b ^ w_c ^ w_d;
      w_k = K1;
    end else if (i_t < 7'd60) begin
      w_f = (w_b & w_c) | (w_b & w_d) | (w_c & w_d);
      w_k = K2;
    end else begin
      w_f = w_b ^ w_c ^ w_d;
      w_k = K3;
    end
  end

  assign w_temp  = rotl5(w_a) + w_f + w_e + w_k + i_w;
  assign o_abcde = {w_temp, w_a, rotl30(w_b), w_c, w_d};

endmodule

// File: rtl/sha1_compress.sv
// SHA-1 compression engine: reads W[0..79] one per cycle, runs 80 rounds,
// then adds the working registers into the saved chaining value.
module sha1_compress
  import sha1_pkg::*;
(
  input  logic           clk,
  input  logic           rst_cmp,
  sha1_compress_if.slave bus,
  output cmp_state_t     o_dbg_state
);

  cmp_state_t r_state, w_state_next;
  state160_t  r_abcde, r_hsave, r_digest, w_round_out;
  logic [6:0] r_t;
  logic       w_accept, w_last_round;

  // The done cycle also accepts so that back-to-back blocks lose no cycle.
  assign w_accept     = bus.cmp_en & bus.ext_done;
  assign w_last_round = (r_t == 7'(ROUNDS - 1));

  sha1_round u_round (
    .i_abcde (r_abcde),
    .i_w     (bus.msg_word),
    .i_t     (r_t),
    .o_abcde (w_round_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst_cmp) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state: 80 ROUND cycles, one FINAL add cycle, one DONE strobe cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_ROUND;
      ST_ROUND: if (w_last_round) w_state_next = ST_FINAL;
      ST_FINAL: w_state_next = ST_DONE;
      ST_DONE:  w_state_next = w_accept ? ST_ROUND : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, step a..e per round, fold into digest in FINAL.
  always_ff @(posedge clk) begin
    if (rst_cmp) begin
      r_abcde  <= '0;
      r_hsave  <= '0;
      r_digest <= '0;
      r_t      <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_abcde <= bus.hash_in;
            r_hsave <= bus.hash_in;
            r_t     <= '0;
          end
        end
        ST_ROUND: begin
          r_abcde <= w_round_out;
          if (!w_last_round) r_t <= r_t + 7'd1;
        end
        ST_FINAL: begin
          for (int i = 0; i < 5; i++) r_digest[i] <= r_hsave[i] + r_abcde[i];
          r_t <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the registered state; index is forced to 0 outside ROUND.
  always_comb begin
    bus.msg_idx  = (r_state == ST_ROUND) ? r_t : 7'd0;
    bus.busy     = (r_state != ST_IDLE);
    bus.cmp_done = (r_state == ST_DONE);
    bus.digest   = r_digest;
    o_dbg_state  = r_state;
  end

endmodule

// File: tb/tb_sha1_compress.sv
// Self-checking bench for sha1_compress against a loop-based SHA-1 model.
module tb_sha1_compress;
  import sha1_pkg::*;

  localparam logic [159:0] KAT_ABC   = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
  localparam logic [159:0] KAT_EMPTY = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;

  logic       clk = 1'b0;
  logic       rst_cmp;
  cmp_state_t dbg_state;

  sha1_compress_if bus();

  sha1_compress dut (
    .clk         (clk),
    .rst_cmp     (rst_cmp),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- schedule memory (stands in for msg_extend) ----------------
  word_t sched [80];
  assign bus.msg_word = (bus.msg_idx < 7'd80) ? sched[bus.msg_idx] : 32'h0;

  // ---------------- scoreboard ----------------
  logic [159:0] exp_q[$];
  logic [159:0] last_dig;
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // kind 0: "abc", 1: empty message, 2: random block
  task automatic load_block(input int kind);
    for (int i = 0; i < 16; i++) sched[i] = 32'h0;
    if (kind == 0) begin
      sched[0]  = 32'h61626380;
      sched[15] = 32'h00000018;
    end else if (kind == 1) begin
      sched[0] = 32'h80000000;
    end else begin
      for (int i = 0; i < 16; i++) sched[i] = $urandom();
    end
    for (int t = 16; t < 80; t++)
      sched[t] = rol(sched[t-3] ^ sched[t-8] ^ sched[t-14] ^ sched[t-16], 1);
  endtask

  function automatic logic [159:0] sha1_model(input logic [159:0] h);
    logic [31:0] hv [5];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int i = 0; i < 5; i++) hv[i] = h[159 - 32*i -: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4];
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = rol(a, 5) + f + e + k + sched[t];
      e = d; d = c; c = rol(b, 30); b = a; a = tmp;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d, hv[4] + e};
  endfunction

  // ---------------- driver tasks ----------------
  // Waits for cmp_done counting edges from the accept edge; tracks the index
  // sweep and that the digest holds its previous value while rounds run.
  task automatic wait_done(input logic [159:0] prev, output int n,
                           output int idx_err, output int hold_err);
    logic [6:0] exp_idx;
    n = 0; idx_err = 0; hold_err = 0;
    while (n < 200) begin
      @(posedge clk); #1; n++;
      if (bus.cmp_done) break;
      exp_idx = (n <= 79) ? 7'(n) : 7'd0;
      if (bus.msg_idx !== exp_idx) idx_err++;
      if (bus.digest !== prev) hold_err++;
    end
    check("done_seen", 160'(bus.cmp_done), 160'(1));
  endtask

  task automatic do_compress(input string tag, input int kind,
                             input logic [159:0] h, input int gate);
    logic [159:0] e;
    int n, ie, he, gerr;
    load_block(kind);
    e = sha1_model(h);
    exp_q.push_back(e);
    @(negedge clk);
    bus.cmp_en = 1'b1; bus.ext_done = 1'b0; bus.hash_in = h;
    gerr = 0;
    repeat (gate) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b0 || bus.cmp_done !== 1'b0 || bus.msg_idx !== 7'd0) gerr++;
    end
    if (gate > 0) check({tag, "_gate"}, 160'(gerr), 160'(0));
    @(negedge clk); bus.ext_done = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy"}, 160'(bus.busy), 160'(1));
    check({tag, "_idx0"}, 160'(bus.msg_idx), 160'(0));
    bus.cmp_en  = 1'b0;
    bus.hash_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    wait_done(last_dig, n, ie, he);
    check({tag, "_lat"},   160'(n),  160'(81));
    check({tag, "_sweep"}, 160'(ie), 160'(0));
    check({tag, "_hold"},  160'(he), 160'(0));
    check({tag, "_digest"}, bus.digest, exp_q.pop_front());
    last_dig = e;
    @(posedge clk); #1;
    check({tag, "_idle"}, 160'(bus.busy), 160'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [159:0] d1, d2, hr;
    int n, ie, he;

    bus.cmp_en = 1'b0; bus.ext_done = 1'b0; bus.hash_in = '0;
    rst_cmp = 1'b1; last_dig = '0;
    for (int i = 0; i < 80; i++) sched[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   160'(bus.busy),     160'(0));
    check("rst_done",   160'(bus.cmp_done), 160'(0));
    check("rst_digest", bus.digest,         160'(0));
    check("rst_idx",    160'(bus.msg_idx),  160'(0));
    check("rst_state",  160'(dbg_state),    160'(ST_IDLE));
    @(negedge clk); rst_cmp = 1'b0;

    // Known answers; the empty block also exercises ext_done gating.
    do_compress("abc", 0, H_INIT, 0);
    check("abc_kat", bus.digest, KAT_ABC);
    do_compress("empty", 1, H_INIT, 10);
    check("empty_kat", bus.digest, KAT_EMPTY);

    // Random blocks with random chaining values.
    for (int i = 0; i < 3; i++) begin
      hr = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      do_compress("rand", 2, hr, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of round 40 discards the run.
    load_block(0);
    @(negedge clk);
    bus.cmp_en = 1'b1; bus.ext_done = 1'b1; bus.hash_in = H_INIT;
    @(posedge clk); #1;
    bus.cmp_en = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk); rst_cmp = 1'b1;
    @(posedge clk); #1;
    check("mrst_busy",   160'(bus.busy),     160'(0));
    check("mrst_done",   160'(bus.cmp_done), 160'(0));
    check("mrst_digest", bus.digest,         160'(0));
    check("mrst_state",  160'(dbg_state),    160'(ST_IDLE));
    rst_cmp = 1'b0; last_dig = '0;
    do_compress("abc_rst", 0, H_INIT, 0);
    check("abc_rst_kat", bus.digest, KAT_ABC);

    // Back-to-back two-block chaining with cmp_en held high.
    load_block(2);
    d1 = sha1_model(H_INIT);
    exp_q.push_back(d1);
    @(negedge clk);
    bus.cmp_en = 1'b1; bus.ext_done = 1'b1; bus.hash_in = H_INIT;
    @(posedge clk); #1;
    wait_done(last_dig, n, ie, he);
    check("b2b_lat1", 160'(n), 160'(81));
    check("b2b_dig1", bus.digest, exp_q.pop_front());
    load_block(2);
    d2 = sha1_model(d1);
    exp_q.push_back(d2);
    bus.hash_in = d1;
    @(posedge clk); #1;
    check("b2b_busy", 160'(bus.busy), 160'(1));
    bus.cmp_en = 1'b0;
    wait_done(d1, n, ie, he);
    check("b2b_gap",   160'(n + 1), 160'(82));
    check("b2b_sweep", 160'(ie),    160'(0));
    check("b2b_hold",  160'(he),    160'(0));
    check("b2b_dig2",  bus.digest,  exp_q.pop_front());
    @(posedge clk); #1;
    check("b2b_idle", 160'(bus.busy), 160'(0));

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
